alu_seq: RTL and testbench

- Parametrised successor to the 8-bit 6502-style ALU: a WIDTH-bit ALU with full in-block decimal correction, rotate-right through carry, and an iterative unsigned multiplier.
- Single-cycle ops complete on one clock edge. Multiply runs WIDTH iterations behind a start/busy/done handshake.
- Sits between the register file / operand muxes and the flag register, under the global RDY stall.

---
 rtl/alu_seq_pkg.sv | 31 +++
 rtl/alu_nibble_add.sv | 42 ++++
 rtl/alu_seq.sv | 216 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM encoding and sizing helper for the sequential ALU.
package alu_seq_pkg;

    localparam logic [3:0] OP_ROR  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_MUL  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_DBL  = 4'b1011;
    localparam logic [3:0] OP_OR   = 4'b1100;
    localparam logic [3:0] OP_AND  = 4'b1101;
    localparam logic [3:0] OP_XOR  = 4'b1110;
    localparam logic [3:0] OP_PASS = 4'b1111;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int bits;
        int span;
        bits = 0;
        span = 32'sd1;
        while (span < value) begin
            span = span * 32'sd2;
            bits = bits + 32'sd1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/alu_nibble_add.sv
// One 4-bit adder slice with optional decimal correction; b is already
// inverted by the caller for subtraction.
module alu_nibble_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    input  logic       bcd,
    input  logic       sub,
    output logic [3:0] s,
    output logic       c_out
);

    logic [4:0] raw_s;

    assign raw_s = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};

    // Decimal add forces a carry past 9; decimal subtract undoes the +6 skew on borrow.
    always_comb begin
        s     = raw_s[3:0];
        c_out = raw_s[4];
        if (bcd && !sub) begin
            if (raw_s >= 5'd10) begin
                s     = raw_s[3:0] + 4'd6;
                c_out = 1'b1;
            end else begin
                s     = raw_s[3:0];
                c_out = raw_s[4];
            end
        end else if (bcd && sub) begin
            if (!raw_s[4]) begin
                s = raw_s[3:0] - 4'd6;
            end else begin
                s = raw_s[3:0];
            end
            c_out = raw_s[4];
        end else begin
            s     = raw_s[3:0];
            c_out = raw_s[4];
        end
    end

endmodule

// File: rtl/alu_seq.sv
// WIDTH-bit ALU: single-cycle add/sub/logic/rotate with decimal correction,
// plus an iterative shift-add unsigned multiplier behind start/busy/done.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdy,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] ai,
    input  logic [WIDTH-1:0] bi,
    input  logic             ci,
    input  logic             bcd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             co,
    output logic             v,
    output logic             z,
    output logic             n,
    output logic             hc
);

    localparam int               NSL      = WIDTH / 4;
    localparam int               CW       = clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

    state_t             state_r, next_state_s;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   mcand_r, mplier_r, acc_hi_r;
    logic [WIDTH-1:0]   out_r, out_hi_r;
    logic               co_r, v_r, z_r, n_r, hc_r, done_r;

    logic               is_mul_op_s, mul_start_s, mul_step_s, mul_last_s, alu_done_s;
    logic [WIDTH-1:0]   b_eff_s, sum_s, res_s;
    logic               c_first_s, sub_s, res_co_s, res_v_s, res_hc_s, r_msb_s;
    logic [NSL:0]       carry_s;
    logic [WIDTH:0]     mul_add_s;
    logic [2*WIDTH-1:0] prod_next_s;

    function automatic logic sum_msb(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic c);
        logic [WIDTH-1:0] t;
        t = a + b + {{(WIDTH-1){1'b0}}, c};
        return t[WIDTH-1];
    endfunction

    assign is_mul_op_s = (MUL_EN == 1'b1) && (op == OP_MUL);

    // Adder operand select; ci only enters the chain for the three adder ops.
    always_comb begin
        b_eff_s   = bi;
        c_first_s = 1'b0;
        sub_s     = 1'b0;
        case (op)
            OP_ADD:  begin b_eff_s = bi;  c_first_s = ci; end
            OP_SUB:  begin b_eff_s = ~bi; c_first_s = ci; sub_s = 1'b1; end
            OP_DBL:  begin b_eff_s = ai;  c_first_s = ci; end
            default: begin b_eff_s = bi;  c_first_s = 1'b0; end
        endcase
    end

    assign carry_s[0] = c_first_s;
    for (genvar g = 0; g < NSL; g++) begin : g_slice
        alu_nibble_add u_slice (
            .a     (ai[4*g +: 4]),
            .b     (b_eff_s[4*g +: 4]),
            .c_in  (carry_s[g]),
            .bcd   (bcd),
            .sub   (sub_s),
            .s     (sum_s[4*g +: 4]),
            .c_out (carry_s[g+1])
        );
    end

    // Overflow is judged on the plain binary sum, never the decimal-corrected one.
    assign r_msb_s = sum_msb(ai, b_eff_s, c_first_s);

    // Single-cycle result and flag candidates.
    always_comb begin
        res_s    = ai;
        res_co_s = 1'b0;
        res_v_s  = 1'b0;
        res_hc_s = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_DBL: begin
                res_s    = sum_s;
                res_co_s = carry_s[NSL];
                res_hc_s = carry_s[1];
                res_v_s  = (ai[WIDTH-1] ^ r_msb_s) & (b_eff_s[WIDTH-1] ^ r_msb_s);
            end
            OP_OR:   res_s = ai | bi;
            OP_AND:  res_s = ai & bi;
            OP_XOR:  res_s = ai ^ bi;
            OP_PASS: res_s = ai;
            OP_ROR:  begin res_s = {ci, ai[WIDTH-1:1]}; res_co_s = ai[0]; end
            default: res_s = ai;
        endcase
    end

    // One shift-add step: add multiplicand into the high half if the next multiplier bit is set.
    assign mul_add_s   = {1'b0, acc_hi_r} + {1'b0, (mplier_r[0] ? mcand_r : {WIDTH{1'b0}})};
    assign prod_next_s = {mul_add_s, mplier_r[WIDTH-1:1]};

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else if (rdy) begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start && is_mul_op_s) next_state_s = MUL;
                else                      next_state_s = IDLE;
            end
            MUL: begin
                if (cnt_r == CNT_LAST) next_state_s = IDLE;
                else                   next_state_s = MUL;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // FSM control outputs.
    always_comb begin
        mul_start_s = 1'b0;
        mul_step_s  = 1'b0;
        mul_last_s  = 1'b0;
        alu_done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                mul_start_s = start && is_mul_op_s;
                alu_done_s  = start && !is_mul_op_s;
            end
            MUL: begin
                mul_step_s = 1'b1;
                mul_last_s = (cnt_r == CNT_LAST);
            end
            default: begin
                mul_start_s = 1'b0;
                alu_done_s  = 1'b0;
            end
        endcase
    end

    // Multiplier operand latch, iteration counter and partial-product shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_hi_r <= '0;
        end else if (rdy) begin
            if (mul_start_s) begin
                cnt_r    <= '0;
                mcand_r  <= ai;
                mplier_r <= bi;
                acc_hi_r <= '0;
            end else if (mul_step_s) begin
                cnt_r                <= cnt_r + CNT_ONE;
                {acc_hi_r, mplier_r} <= prod_next_s;
            end
        end
    end

    // Result/flag registers; they hold until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r    <= '0;
            out_hi_r <= '0;
            {co_r, v_r, z_r, n_r, hc_r} <= 5'b00000;
            done_r   <= 1'b0;
        end else if (rdy) begin
            done_r <= alu_done_s | mul_last_s;
            if (alu_done_s) begin
                out_r    <= res_s;
                out_hi_r <= '0;
                co_r     <= res_co_s;
                v_r      <= res_v_s;
                hc_r     <= res_hc_s;
                z_r      <= (res_s == '0);
                n_r      <= res_s[WIDTH-1];
            end else if (mul_last_s) begin
                {out_hi_r, out_r} <= prod_next_s;
                co_r <= |prod_next_s[2*WIDTH-1:WIDTH];
                n_r  <= prod_next_s[2*WIDTH-1];
                z_r  <= (prod_next_s == '0);
                v_r  <= 1'b0;
                hc_r <= 1'b0;
            end
        end
    end

    assign busy   = (state_r == MUL);
    assign done   = done_r;
    assign out    = out_r;
    assign out_hi = out_hi_r;
    assign co     = co_r;
    assign v      = v_r;
    assign z      = z_r;
    assign n      = n_r;
    assign hc     = hc_r;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): a decimal/integer reference model
// compared every cycle, plus literal expectations from hand-worked vectors.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n, rdy, start, ci, bcd;
    logic [3:0]   op;
    logic [W-1:0] ai, bi;
    logic         busy, done, co, v, z, n, hc;
    logic [W-1:0] out, out_hi;
    logic         busy0, done0, co0, v0, z0, n0, hc0;
    logic [W-1:0] out0, out_hi0;

    int n_chk  = 0;
    int n_pass = 0;
    logic chk_en = 1'b0;

    alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .start(start), .op(op), .ai(ai), .bi(bi),
        .ci(ci), .bcd(bcd), .busy(busy), .done(done), .out(out), .out_hi(out_hi),
        .co(co), .v(v), .z(z), .n(n), .hc(hc));

    alu_seq #(.WIDTH(W), .MUL_EN(1'b0)) u_dut_nomul (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .start(start), .op(op), .ai(ai), .bi(bi),
        .ci(ci), .bcd(bcd), .busy(busy0), .done(done0), .out(out0), .out_hi(out_hi0),
        .co(co0), .v(v0), .z(z0), .n(n0), .hc(hc0));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] o;
        logic [W-1:0] oh;
        logic co, v, z, n, hc;
    } res_t;

    res_t           exp_r     = '0;
    logic           exp_busy  = 1'b0;
    logic           exp_done  = 1'b0;
    int             mul_left  = 0;
    logic [2*W-1:0] mul_prod  = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    endtask

    function automatic int bcd2int(input logic [W-1:0] x);
        int r = 0;
        for (int i = W/4 - 1; i >= 0; i--) r = r * 10 + int'(x[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int x);
        logic [W-1:0] r = '0;
        int t = x;
        for (int i = 0; i < W/4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Reference result of one single-cycle op, from arithmetic meaning.
    function automatic res_t single(input logic [3:0] o, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input logic c, input logic d);
        res_t r;
        logic [W-1:0] be, bb;
        logic [W:0] t;
        int s, ia, ib, ir, lim;
        r = '0;
        r.o = a;
        case (o)
            4'b0011, 4'b0111, 4'b1011: begin
                bb = (o == 4'b1011) ? a : b;
                be = (o == 4'b0111) ? ~b : bb;
                s = int'($signed(a)) + int'($signed(be)) + int'(c);
                r.v = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
                if (!d) begin
                    t = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, c};
                    r.o = t[W-1:0];
                    r.co = t[W];
                    r.hc = (int'(a[3:0]) + int'(be[3:0]) + int'(c)) > 15;
                end else begin
                    lim = 1;
                    for (int i = 0; i < W/4; i++) lim = lim * 10;
                    ia = bcd2int(a);
                    ib = bcd2int(bb);
                    if (o == 4'b0111) begin
                        ir = ia - ib - (1 - int'(c));
                        r.co = (ir >= 0);
                        r.hc = (int'(a[3:0]) - int'(b[3:0]) - (1 - int'(c))) >= 0;
                        if (ir < 0) ir = ir + lim;
                    end else begin
                        ir = ia + ib + int'(c);
                        r.co = (ir >= lim);
                        r.hc = (int'(a[3:0]) + int'(bb[3:0]) + int'(c)) >= 10;
                        if (ir >= lim) ir = ir - lim;
                    end
                    r.o = int2bcd(ir);
                end
            end
            4'b1100: r.o = a | b;
            4'b1101: r.o = a & b;
            4'b1110: r.o = a ^ b;
            4'b0000: begin r.o = {c, a[W-1:1]}; r.co = a[0]; end
            default: r.o = a;
        endcase
        r.n = r.o[W-1];
        r.z = (r.o == '0);
        return r;
    endfunction

    function automatic res_t mul_res(input logic [2*W-1:0] p);
        res_t r;
        r = '0;
        r.oh = p[2*W-1:W];
        r.o  = p[W-1:0];
        r.co = (r.oh != '0);
        r.n  = r.oh[W-1];
        r.z  = (p == '0);
        return r;
    endfunction

    // Reference model: multiply is a countdown of W enabled edges then publish.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_r <= '0; exp_busy <= 1'b0; exp_done <= 1'b0; mul_left <= 0; mul_prod <= '0;
        end else if (rdy) begin
            if (mul_left != 0) begin
                mul_left <= mul_left - 1;
                exp_done <= (mul_left == 1);
                if (mul_left == 1) begin
                    exp_r    <= mul_res(mul_prod);
                    exp_busy <= 1'b0;
                end
            end else if (start && op == 4'b0100) begin
                mul_left <= W;
                mul_prod <= {{W{1'b0}}, ai} * {{W{1'b0}}, bi};
                exp_busy <= 1'b1;
                exp_done <= 1'b0;
            end else if (start) begin
                exp_r    <= single(op, ai, bi, ci, bcd);
                exp_done <= 1'b1;
            end else begin
                exp_done <= 1'b0;
            end
        end
    end

    // Every-cycle comparison, sampled 4 time units after the rising edge.
    always @(posedge clk) begin
        #4;
        if (chk_en) begin
            check("out", out, exp_r.o);
            check("out_hi", out_hi, exp_r.oh);
            check("co", co, exp_r.co);
            check("v", v, exp_r.v);
            check("z", z, exp_r.z);
            check("n", n, exp_r.n);
            check("hc", hc, exp_r.hc);
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            check("nomul_busy", busy0, 1'b0);
        end
    end

    task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic d);
        @(negedge clk);
        op = o; ai = a; bi = b; ci = c; bcd = d; start = 1'b1;
        @(posedge clk);
        #4;
        start = 1'b0;
    endtask

    int cyc;
    int bcnt;

    initial begin
        rst_n = 1'b0; rdy = 1'b1; start = 1'b0; op = 4'b0000;
        ai = '0; bi = '0; ci = 1'b0; bcd = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out", out, 8'h00);
        check("rst_flags", {busy, done, co, v, z, n, hc}, 7'b0000000);
        rst_n = 1'b1;

        issue(4'b0011, 8'h7F, 8'h01, 1'b0, 1'b0);
        check("add_out", out, 8'h80);
        check("add_flags", {n, v, hc, co, z, done}, 6'b111001);
        check("add_model", exp_r.o, 8'h80);
        issue(4'b0011, 8'h58, 8'h46, 1'b1, 1'b1);
        check("bcdadd_out", out, 8'h05);
        check("bcdadd_co_hc", {co, hc, done}, 3'b111);
        check("bcdadd_model", {exp_r.o, exp_r.co, exp_r.hc}, {8'h05, 2'b11});
        issue(4'b0111, 8'h10, 8'h01, 1'b1, 1'b1);
        check("bcdsub_out", out, 8'h09);
        check("bcdsub_co_hc", {co, hc}, 2'b10);
        issue(4'b0000, 8'h81, 8'h00, 1'b1, 1'b0);
        check("ror_out", {out, co, n}, {8'hC0, 2'b11});
        issue(4'b1101, 8'hF0, 8'h3C, 1'b1, 1'b0);
        check("and_out", {out, co}, {8'h30, 1'b0});
        issue(4'b1100, 8'hF0, 8'h3C, 1'b0, 1'b0);
        issue(4'b1110, 8'hF0, 8'h3C, 1'b0, 1'b0);
        issue(4'b1111, 8'h6B, 8'h11, 1'b1, 1'b0);
        issue(4'b1011, 8'h45, 8'h00, 1'b0, 1'b1);
        check("bcddbl_out", {out, hc, co}, {8'h90, 2'b10});
        issue(4'b0111, 8'h05, 8'h05, 1'b1, 1'b0);
        check("sub_zero", {out, z, co}, {8'h00, 2'b11});
        issue(4'b0111, 8'h00, 8'h01, 1'b1, 1'b0);
        check("sub_borrow", {out, co, n}, {8'hFF, 2'b01});
        issue(4'b1011, 8'hC0, 8'h00, 1'b1, 1'b0);
        issue(4'b1000, 8'hA5, 8'h00, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("done_clears", done, 1'b0);

        // Plain multiply: count busy samples up to completion.
        issue(4'b0100, 8'hFF, 8'hFF, 1'b0, 1'b0);
        check("mul_busy_start", busy, 1'b1);
        bcnt = 1; cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge clk); #4;
            cyc++;
            if (busy) bcnt++;
        end
        check("mul_timeout", done, 1'b1);
        check("mul_busy_cycles", bcnt, 8);
        check("mul_result", {out_hi, out, co, z}, {8'hFE, 8'h01, 2'b10});

        // Multiply with a 3-cycle rdy stall and an ignored start while busy.
        issue(4'b0100, 8'h12, 8'h34, 1'b0, 1'b0);
        cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge clk); #4;
            cyc++;
            if (cyc == 2) rdy = 1'b0;
            if (cyc == 5) rdy = 1'b1;
            if (cyc == 6) begin op = 4'b0011; ai = 8'h01; bi = 8'h01; start = 1'b1; end
            if (cyc == 7) start = 1'b0;
        end
        check("stall_timeout", done, 1'b1);
        check("stall_latency", cyc, 11);
        check("stall_result", {out_hi, out}, 16'h03A8);
        @(negedge clk);

        // Reset during iteration 4 abandons the multiply.
        issue(4'b0100, 8'h0F, 8'h0F, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out", {out_hi, out}, 16'h0000);
        check("midrst_flags", {busy, done, co, v, z, n, hc}, 7'b0000000);
        @(negedge clk);
        rst_n = 1'b1;
        issue(4'b0011, 8'h12, 8'h34, 1'b0, 1'b0);
        check("post_rst_add", {out, done, busy}, {8'h46, 2'b10});

        // Op 0100 is a plain pass on the MUL_EN=0 instance.
        issue(4'b0100, 8'h5A, 8'h03, 1'b0, 1'b0);
        check("nomul_out", {out0, co0, busy0, done0}, {8'h5A, 3'b001});
        cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge clk); #4;
            cyc++;
        end
        check("mul2_timeout", done, 1'b1);
        check("mul2_result", {out_hi, out}, 16'h010E);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
